vdec1_derm_stream: RTL and testbench
====================================

Name: vdec1_derm_stream

Overview:
- Streaming de-ratematcher ahead of the Viterbi core. It accepts received soft symbols over a valid/ready handshake and re-expands them to the mother-code length. A zero-valued erasure symbol is inserted at every punctured position.
- Supports the three fixed HS patterns (part1, part2, agch) plus one programmable pattern. Soft width and maximum length are parametrised.
- Sits between the symbol demux and the vdec1 branch-metric unit. Drives one frame per start pulse.

Parameters:
- SW, 6, soft-symbol width in bits (signed two's complement).
- IW, 7, index counter width; maximum mother length is 2^IW.
- MAXLEN, 128, width of the programmable puncture map; must be at most 2^IW.

Ports:
- clk  input  1  system clock, 307.2 MHz.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle frame start pulse; honoured only in IDLE.
- hs_mode  input  2  pattern select, sampled on start: 00 part1, 01 part2, 10 agch, 11 programmable.
- cfg_len  input  IW  programmable mother length minus 1; sampled on start; used only in mode 11.
- cfg_map  input  MAXLEN  programmable puncture map, bit i=1 means index i is punctured; must be held stable for the whole frame.
- in_vld  input  1  input soft symbol valid.
- in_data  input  SW  received soft symbol.
- in_rdy  output  1  input ready.
- out_vld  output  1  output symbol valid.
- out_data  output  SW  de-ratematched symbol; 0 on erasure.
- out_era  output  1  current output is an inserted erasure.
- out_last  output  1  current output is mother index len-1.
- out_rdy  input  1  downstream ready.
- busy  output  1  frame in progress (state is not IDLE).
- done  output  1  one-cycle pulse when the last output is accepted.

Behaviour:
- Reset values: in_rdy=0, out_vld=0, out_data=0, out_era=0, out_last=0, busy=0, done=0. The state machine resets to IDLE and idx to 0.
- Fixed patterns use 0-based indices; they are mode-internal constants.
  - part1: len 48; punctured {0,1,3,7,41,44,46,47}. 40 received symbols.
  - part2: len 111; punctured {0-7,11,13,14,23,41,47,53,56,59,65,68,95,98,100,101,103-110}. 80 received symbols.
  - agch: len 90; punctured {0,1,4,5,6,10,11,13,14,16,22,23,30,36,43,46,60,62,63,70,71,74,76,79,82,83,84,86,87,89}. 60 received symbols.
  - mode 11: len = cfg_len+1; punctured[i] = cfg_map[i]. Indices at or above MAXLEN count as not punctured.
- State machine:
  - IDLE: on start, latch mode and length, clear idx, go to RUN.
  - RUN: one mother index is produced per output-register load. When the symbol for index len-1 is loaded, go to DRAIN.
  - DRAIN: when out_vld and out_rdy, pulse done and go to IDLE.
- Output register is a single stage. The register may load when it is empty (out_vld=0) or when it is being drained in the same cycle (out_rdy=1).
- Load rules in RUN:
  - If punc(idx)=1: load out_data=0, out_era=1. in_data is not consumed. in_rdy=0.
  - If punc(idx)=0: in_rdy=1 whenever the register may load. On in_vld and in_rdy, load out_data=in_data, out_era=0.
  - Each load increments idx. out_last=1 when the loaded idx equals len-1.
- Latency is one cycle from input acceptance (or erasure generation) to out_vld. Full throughput is one symbol per clock while out_rdy=1. Erasure runs do not stall.
- in_rdy is 0 in IDLE and DRAIN, and is never asserted at a punctured index.
- out_data, out_era and out_last stay stable while out_vld=1 and out_rdy=0.
- start while busy is ignored; the frame in progress is unaffected. start in the same cycle as done is also ignored; start must arrive in IDLE.
- mode 11 with cfg_len=0: a one-symbol frame.
- Asserting rst_n low mid-frame aborts the frame immediately. No done pulse is produced, and all outputs return to their reset values.
- An extra input beyond the frame length is never accepted, because in_rdy=0 after the final load.
- idx arithmetic is unsigned IW-bit. Wrap cannot occur, since the length is at most 2^IW.

Test Plan:
- part1, in_vld held high, out_rdy high, inputs 1..40 → 48 outputs over 48 consecutive cycles. Erasures at idx 0,1,3,7,41,44,46,47. idx2=1, idx4=2, idx48-1 is an erasure with out_last=1. done pulses one cycle after the last output is accepted.
- agch with random out_rdy backpressure (50%) and random in_vld gaps → exactly 60 inputs consumed and 90 outputs. The erasure set matches the agch list. Outputs are held stable under stall, and no input is accepted at a punctured index.
- part2, inputs 1..80 → first 8 outputs are erasures and the first data output is idx8=1. Erasures at idx 103-110 are emitted back-to-back with in_rdy=0 throughout.
- mode 11, cfg_len=9, cfg_map=0x205 → erasures at idx 0,2,9, 7 inputs consumed. Repeat with cfg_len=0, cfg_map=0: a single output that has both out_last=1 and done.
- start pulsed again mid-frame in part1 → ignored. Frame completes normally and busy stays 1 until done.
- rst_n asserted after 20 outputs of part2 → in_rdy, out_vld and busy go to 0 with no done pulse. A new start after release runs a clean frame from idx 0.

Source files
------------

// File: rtl/vdec1_derm_stream.sv
// vdec1_derm_stream
//   Streaming de-ratematcher feeding the vdec1 branch-metric unit. Received
//   soft symbols are re-expanded to the mother-code length; every punctured
//   mother index gets a zero-valued erasure symbol. One frame per start pulse.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 frame start pulse (honoured in IDLE only)
//   hs_mode               pattern select sampled on start
//                         (00 part1, 01 part2, 10 agch, 11 programmable)
//   cfg_len               programmable mother length - 1 (mode 11)
//   cfg_map               programmable puncture map, bit i=1 -> punctured
//   in_vld/in_data/in_rdy received soft symbol stream
//   out_vld/out_data/out_era/out_last/out_rdy  mother-length symbol stream
//   busy                  frame in progress
//   done                  pulse after the last output is accepted
module vdec1_derm_stream #(
    parameter int SW     = 6,
    parameter int IW     = 7,
    parameter int MAXLEN = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        hs_mode,
    input  logic [IW-1:0]     cfg_len,
    input  logic [MAXLEN-1:0] cfg_map,
    input  logic              in_vld,
    input  logic [SW-1:0]     in_data,
    output logic              in_rdy,
    output logic              out_vld,
    output logic [SW-1:0]     out_data,
    output logic              out_era,
    output logic              out_last,
    input  logic              out_rdy,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [1:0] M_P1   = 2'd0;
    localparam logic [1:0] M_P2   = 2'd1;
    localparam logic [1:0] M_AGCH = 2'd2;

    // Fixed patterns stored as last index (length - 1).
    localparam logic [IW-1:0] P1_LAST   = IW'(47);
    localparam logic [IW-1:0] P2_LAST   = IW'(110);
    localparam logic [IW-1:0] AGCH_LAST = IW'(89);

    function automatic logic punc_p1(input int i);
        case (i)
            0, 1, 3, 7, 41, 44, 46, 47: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic punc_p2(input int i);
        case (i) inside
            [0:7], 11, 13, 14, 23, 41, 47, 53, 56, 59, 65, 68,
            95, 98, 100, 101, [103:110]: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic punc_agch(input int i);
        case (i)
            0, 1, 4, 5, 6, 10, 11, 13, 14, 16, 22, 23, 30, 36, 43, 46,
            60, 62, 63, 70, 71, 74, 76, 79, 82, 83, 84, 86, 87, 89: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              out_vld_q, out_vld_d;
    logic [SW-1:0]     out_data_q, out_data_d;
    logic              out_era_q, out_era_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;

    logic              punc;
    logic              can_load;
    logic              load;
    logic [MAXLEN-1:0] map_sh;

    always_comb begin
        map_sh = cfg_map >> idx_q;
        punc   = 1'b0;
        case (mode_q)
            M_P1:    punc = punc_p1(int'(idx_q));
            M_P2:    punc = punc_p2(int'(idx_q));
            M_AGCH:  punc = punc_agch(int'(idx_q));
            // indices beyond the map width are never punctured
            default: punc = (int'(idx_q) < MAXLEN) && map_sh[0];
        endcase
    end

    // Output register is free when empty or being drained this cycle.
    assign can_load = !out_vld_q || out_rdy;
    assign in_rdy   = (state_q == S_RUN) && can_load && !punc;
    // Erasures load without waiting for input.
    assign load     = (state_q == S_RUN) && can_load && (punc || in_vld);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        last_d     = last_q;
        idx_d      = idx_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_era_d  = out_era_q;
        out_last_d = out_last_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q high means the previous frame ended this cycle
                if (start && !done_q) begin
                    state_d = S_RUN;
                    mode_d  = hs_mode;
                    idx_d   = '0;
                    case (hs_mode)
                        M_P1:    last_d = P1_LAST;
                        M_P2:    last_d = P2_LAST;
                        M_AGCH:  last_d = AGCH_LAST;
                        default: last_d = cfg_len;
                    endcase
                end
            end
            S_RUN: begin
                if (load) begin
                    out_vld_d  = 1'b1;
                    out_data_d = punc ? '0 : in_data;
                    out_era_d  = punc;
                    out_last_d = (idx_q == last_q);
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == last_q)
                        state_d = S_DRAIN;
                end else if (out_rdy) begin
                    out_vld_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (out_vld_q && out_rdy) begin
                    out_vld_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            last_q     <= '0;
            idx_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_era_q  <= 1'b0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_era_q  <= out_era_d;
            out_last_q <= out_last_d;
            done_q     <= done_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_era  = out_era_q;
    assign out_last = out_last_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_vdec1_derm_stream.sv
// Bench for vdec1_derm_stream: table of frame scenarios checked against a
// list-based reference of the puncture patterns, plus reset/restart corners.
module tb_vdec1_derm_stream;

    localparam int SW     = 6;
    localparam int IW     = 7;
    localparam int MAXLEN = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        hs_mode = 2'd0;
    logic [IW-1:0]     cfg_len = '0;
    logic [MAXLEN-1:0] cfg_map = '0;
    logic              in_vld = 1'b0;
    logic [SW-1:0]     in_data = '0;
    logic              in_rdy;
    logic              out_vld;
    logic [SW-1:0]     out_data;
    logic              out_era;
    logic              out_last;
    logic              out_rdy = 1'b0;
    logic              busy;
    logic              done;

    vdec1_derm_stream #(.SW(SW), .IW(IW), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hs_mode(hs_mode),
        .cfg_len(cfg_len), .cfg_map(cfg_map), .in_vld(in_vld),
        .in_data(in_data), .in_rdy(in_rdy), .out_vld(out_vld),
        .out_data(out_data), .out_era(out_era), .out_last(out_last),
        .out_rdy(out_rdy), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_len(input logic [1:0] m, input logic [IW-1:0] clen);
        case (m)
            2'd0:    return 48;
            2'd1:    return 111;
            2'd2:    return 90;
            default: return int'(clen) + 1;
        endcase
    endfunction

    function automatic bit ref_punc(input logic [1:0] m, input int i, input logic [MAXLEN-1:0] map);
        int p1[8]  = '{0,1,3,7,41,44,46,47};
        int p2[31] = '{0,1,2,3,4,5,6,7,11,13,14,23,41,47,53,56,59,65,68,95,98,
                       100,101,103,104,105,106,107,108,109,110};
        int ag[30] = '{0,1,4,5,6,10,11,13,14,16,22,23,30,36,43,46,60,62,63,70,
                       71,74,76,79,82,83,84,86,87,89};
        bit hit = 1'b0;
        case (m)
            2'd0: foreach (p1[k]) if (p1[k] == i) hit = 1'b1;
            2'd1: foreach (p2[k]) if (p2[k] == i) hit = 1'b1;
            2'd2: foreach (ag[k]) if (ag[k] == i) hit = 1'b1;
            default: hit = (i < MAXLEN) ? map[i] : 1'b0;
        endcase
        return hit;
    endfunction

    // ---------------- scenario table ----------------
    typedef struct {
        logic [1:0]        mode;
        logic [IW-1:0]     clen;
        logic [MAXLEN-1:0] cmap;
        int                rdy_pct;
        int                vld_pct;
        int                exp_len;
        int                exp_nin;
        int                restart_at;
        int                abort_at;
    } vec_t;

    vec_t tbl[9];

    task automatic run_frame(input int r);
        vec_t              v;
        logic [SW-1:0]     din[$];
        logic [SW+1:0]     expq[$];
        logic [SW+1:0]     prev_vec;
        logic [SW-1:0]     d;
        int len, k, nin, nout, cyc, first, lastc, ndone;
        bit seq, full, last_acc_prev, prev_stall, restarted;
        v = tbl[r];
        len = ref_len(v.mode, v.clen);
        seq = (v.vld_pct == 100);
        full = (v.rdy_pct == 100) && (v.vld_pct == 100) && (v.restart_at < 0) && (v.abort_at < 0);
        k = 0;
        for (int i = 0; i < len; i++) begin
            bit lst = (i == len - 1);
            if (ref_punc(v.mode, i, v.cmap)) begin
                expq.push_back({{SW{1'b0}}, 1'b1, lst});
            end else begin
                d = seq ? SW'(k + 1) : SW'($urandom);
                din.push_back(d);
                expq.push_back({d, 1'b0, lst});
                k++;
            end
        end

        @(negedge clk);
        in_vld = 1'b0; out_rdy = 1'b0;
        hs_mode = v.mode; cfg_len = v.clen; cfg_map = v.cmap; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs_mode = ~v.mode;          // must have been latched on start
        cfg_len = IW'($urandom);

        nin = 0; nout = 0; cyc = 0; first = -1; lastc = -1; ndone = 0;
        last_acc_prev = 0; prev_stall = 0; restarted = 0; prev_vec = '0;
        while (cyc < 3000) begin
            if (v.abort_at >= 0 && nout == v.abort_at) begin
                rst_n = 1'b0; in_vld = 1'b1; out_rdy = 1'b0;
                #1;
                chk("abort_in_rdy", in_rdy, 0);
                chk("abort_out_vld", out_vld, 0);
                chk("abort_busy", busy, 0);
                chk("abort_outs", {out_data, out_era, out_last}, 0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk); #1;
                    chk("abort_no_done", done, 0);
                end
                @(negedge clk);
                rst_n = 1'b1; in_vld = 1'b0;
                @(negedge clk);
                return;
            end
            out_rdy = ($urandom_range(99) < v.rdy_pct);
            in_vld  = ($urandom_range(99) < v.vld_pct);
            in_data = (nin < din.size()) ? din[nin] : SW'($urandom);
            if (v.restart_at >= 0 && nout == v.restart_at && !restarted) begin
                start = 1'b1; hs_mode = 2'd2; cfg_len = '0; restarted = 1;
            end
            #1;
            if (prev_stall)
                chk("stall_hold", {out_vld, out_data, out_era, out_last}, {1'b1, prev_vec});
            if (done) begin
                chk("done_after_last", last_acc_prev, 1);
                chk("busy_at_done", busy, 0);
                ndone++;
                break;
            end
            chk("busy_in_frame", busy, 1);
            if (in_vld && in_rdy) nin++;
            last_acc_prev = 1'b0;
            if (out_vld && out_rdy) begin
                if (nout < len)
                    chk($sformatf("r%0d_out%0d", r, nout), {out_data, out_era, out_last}, expq[nout]);
                else
                    chk("extra_out", nout, len - 1);
                if (first < 0) first = cyc;
                lastc = cyc;
                last_acc_prev = out_last;
                nout++;
            end
            prev_stall = out_vld && !out_rdy;
            prev_vec = {out_data, out_era, out_last};
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk($sformatf("r%0d_done_seen", r), ndone, 1);
        chk($sformatf("r%0d_n_out", r), nout, v.exp_len);
        chk($sformatf("r%0d_n_in", r), nin, v.exp_nin);
        if (full) chk($sformatf("r%0d_back_to_back", r), lastc - first, v.exp_len - 1);

        // start in the done cycle must be ignored; nothing accepted in IDLE
        start = 1'b1; hs_mode = 2'd0; in_vld = 1'b1; out_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("start_at_done_ignored", busy, 0);
        chk("idle_in_rdy", in_rdy, 0);
        chk("idle_no_done", done, 0);
        in_vld = 1'b0;
    endtask

    initial begin
        //            mode   clen      cmap                         rdy  vld  len  nin  rst  abort
        tbl[0] = '{2'd0, 7'd0,   '0,                          100, 100,  48,  40,  -1,  -1};
        tbl[1] = '{2'd2, 7'd0,   '0,                           50,  70,  90,  60,  -1,  -1};
        tbl[2] = '{2'd1, 7'd0,   '0,                          100, 100, 111,  80,  -1,  -1};
        tbl[3] = '{2'd3, 7'd9,   128'h205,                    100, 100,  10,   7,  -1,  -1};
        tbl[4] = '{2'd3, 7'd0,   '0,                          100, 100,   1,   1,  -1,  -1};
        tbl[5] = '{2'd0, 7'd0,   '0,                           80,  80,  48,  40,  10,  -1};
        tbl[6] = '{2'd1, 7'd0,   '0,                          100, 100, 111,  80,  -1,  20};
        tbl[7] = '{2'd1, 7'd0,   '0,                          100, 100, 111,  80,  -1,  -1};
        tbl[8] = '{2'd3, 7'd127, {32{4'b0011}},                60,  60, 128,  64,  -1,  -1};

        #1;
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_era", out_era, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 9; r++) run_frame(r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
